// File: rtl/sram_arb_pkg.sv
// Shared types for the SRAM port arbiter: port identifiers, data width and
// the request bundle that is forwarded to the single-port SRAM.
package sram_arb_pkg;

    localparam int DATA_W        = 8;
    localparam int ARB_ADDR_BITS = 16;

    typedef enum logic {
        PORT_CTRL = 1'b0,
        PORT_HOST = 1'b1
    } port_id_t;

    typedef struct packed {
        logic                     we;
        logic [ARB_ADDR_BITS-1:0] addr;
        logic [DATA_W-1:0]        wdata;
    } mem_req_t;

endpackage

// File: rtl/sram_port_arbiter.sv
// Per-cycle req/gnt arbiter sharing one synchronous SRAM between the control
// unit (port 0) and the JTAG host (port 1), with host anti-starvation.
import sram_arb_pkg::*;

module sram_port_arbiter #(
    parameter int ADDR_BITS = 16,
    parameter int MAX_WAIT  = 8,
    parameter int WAIT_W    = 8
) (
    input  logic                 clk,
    input  logic                 aclr,
    input  logic                 excl,
    input  logic                 p0_req,
    input  logic                 p0_we,
    input  logic [ADDR_BITS-1:0] p0_addr,
    input  logic [DATA_W-1:0]    p0_wdata,
    output logic                 p0_gnt,
    output logic                 p0_rvalid,
    input  logic                 p1_req,
    input  logic                 p1_we,
    input  logic [ADDR_BITS-1:0] p1_addr,
    input  logic [DATA_W-1:0]    p1_wdata,
    output logic                 p1_gnt,
    output logic                 p1_rvalid,
    output logic [DATA_W-1:0]    rdata,
    output logic                 mem_we,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic [DATA_W-1:0]    mem_wdata,
    input  logic [DATA_W-1:0]    mem_rdata,
    output logic [WAIT_W-1:0]    p1_wait_max
);

    localparam logic [WAIT_W-1:0] MAX_WAIT_C = WAIT_W'(MAX_WAIT);

    logic [1:0]        r_rv;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic [WAIT_W-1:0] r_wait_max;

    logic              w_gnt0;
    logic              w_gnt1;
    logic              w_any_gnt;
    port_id_t          w_owner;
    logic              w_p1_denied;
    logic [WAIT_W:0]   w_wait_inc;

    // Grants are masked while aclr is high so nothing reaches the SRAM in reset.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (!aclr) begin
            if (excl) begin
                w_gnt0 = p0_req;
            end else if (p0_req && p1_req) begin
                if (r_wait_cnt == MAX_WAIT_C) begin
                    w_gnt1 = 1'b1;
                end else begin
                    w_gnt0 = 1'b1;
                end
            end else begin
                w_gnt0 = p0_req;
                w_gnt1 = p1_req;
            end
        end
    end

    assign w_any_gnt = w_gnt0 | w_gnt1;
    assign w_owner   = w_gnt1 ? PORT_HOST : PORT_CTRL;

    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (w_any_gnt) begin
            if (w_owner == PORT_HOST) begin
                mem_we    = p1_we;
                mem_addr  = p1_addr;
                mem_wdata = p1_wdata;
            end else begin
                mem_we    = p0_we;
                mem_addr  = p0_addr;
                mem_wdata = p0_wdata;
            end
        end
    end

    assign w_p1_denied = p1_req && !w_gnt1 && !excl;
    assign w_wait_inc  = {1'b0, r_wait_cnt} + (WAIT_W+1)'(1);

    // Wait count is held, not cleared, under excl so the host is served first after it drops.
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            r_rv       <= 2'b00;
            r_wait_cnt <= '0;
            r_wait_max <= '0;
        end else begin
            r_rv <= {w_gnt1 & ~p1_we, w_gnt0 & ~p0_we};

            if (!p1_req || w_gnt1) begin
                r_wait_cnt <= '0;
            end else if (w_p1_denied && r_wait_cnt != MAX_WAIT_C) begin
                r_wait_cnt <= w_wait_inc[WAIT_W-1:0];
            end

            if (w_p1_denied && w_wait_inc > {1'b0, r_wait_max}) begin
                r_wait_max <= w_wait_inc[WAIT_W] ? '1 : w_wait_inc[WAIT_W-1:0];
            end
        end
    end

    assign p0_gnt      = w_gnt0;
    assign p1_gnt      = w_gnt1;
    assign p0_rvalid   = r_rv[0];
    assign p1_rvalid   = r_rv[1];
    assign rdata       = mem_rdata;
    assign p1_wait_max = r_wait_max;

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Shares the single-port 8-bit SRAM (`mem_sram_simple`, synchronous read, 1-cycle latency) between two requesters.
  - Port 0: the control-unit datapath.
  - Port 1: the JTAG host interface.
- Replaces the static busy-based mux with a per-cycle req/gnt arbiter, an anti-starvation guarantee for the host and read-data return tagging.
- Sits between `connect`/`control_unit` and the RAM instance in `top`.

Parameters:
- ADDR_BITS, 16, SRAM address width.
- MAX_WAIT, 8, maximum consecutive denied cycles for port 1 before it is forced a grant (1..255).
- WAIT_W, 8, width of the wait counter and of the stat output.

Ports:
- clk  in  1  system clock (CLOCK_50 domain).
- aclr  in  1  asynchronous reset, active-high.
- excl  in  1  exclusive mode for port 0 (control unit busy); port 1 is never granted while high.
- p0_req  in  1  port 0 access request.
- p0_we  in  1  port 0 write enable (1 = write, 0 = read).
- p0_addr  in  ADDR_BITS  port 0 address.
- p0_wdata  in  8  port 0 write data.
- p0_gnt  out  1  port 0 access accepted this cycle.
- p0_rvalid  out  1  port 0 read data valid.
- p1_req, p1_we, p1_addr, p1_wdata, p1_gnt, p1_rvalid: same as port 0, for port 1.
- rdata  out  8  read data, broadcast to both ports; qualify with pN_rvalid.
- mem_we  out  1  SRAM write enable.
- mem_addr  out  ADDR_BITS  SRAM address.
- mem_wdata  out  8  SRAM write data.
- mem_rdata  in  8  SRAM read data (registered inside the SRAM).
- p1_wait_max  out  WAIT_W  worst-case port 1 wait in cycles since reset; saturating.

Behaviour:
- Grant is combinational from req, excl and the registered state. Accepted means pN_req && pN_gnt in the same cycle. At most one gnt is high per cycle.
- Grant rules, first match wins:
  - 1. excl=1: p0_gnt=p0_req, p1_gnt=0.
  - 2. Both req and wait_cnt==MAX_WAIT: p1 wins.
  - 3. Both req: p0 wins.
  - 4. Single req: that port wins.
- SRAM drive:
  - Granted port's we/addr/wdata pass straight to mem_*.
  - No grant: mem_we=0, mem_addr=0, mem_wdata=0.
- Read return:
  - On an accepted read (we=0), a registered tag rv_q[1:0] sets the owner bit for exactly the next cycle.
  - pN_rvalid = rv_q[N]; rdata = mem_rdata. Read latency is 1 cycle from grant.
  - Back-to-back reads from alternating ports each get their own rvalid cycle. No bubbles.
- Writes: complete at the accepting edge. No rvalid. A read accepted the cycle after a write to the same address returns the new data.
- wait_cnt (WAIT_W bits):
  - Increments when p1_req && !p1_gnt && !excl.
  - Clears on a p1 grant, or when p1_req=0.
  - Held (not cleared) while excl=1, so the host is served promptly once excl drops.
  - Saturates at MAX_WAIT.
- p1_wait_max: updated to wait_cnt+1 whenever that value exceeds the stored maximum. Saturates at 2^WAIT_W-1.
- Reset (aclr=1, asynchronous):
  - rv_q=0, wait_cnt=0, p1_wait_max=0.
  - While aclr is high, both gnt=0 and mem_we=0, masked combinationally.
  - A read in flight when reset asserts yields no rvalid.
- excl rising while p1 has a read in flight: that rvalid still fires next cycle.
- Requesters hold req/we/addr/wdata stable until gnt. The arbiter does not latch request fields.

Decomposition:
- Package `sram_arb_pkg`:
  - DATA_W=8
  - typedef enum logic {PORT_CTRL=0, PORT_HOST=1} port_id_t
  - typedef struct {we, addr, wdata} mem_req_t, parameterised by ADDR_BITS via a localparam
- No sub-module is needed. The wait/stat counters stay inline.

Test Plan:
- Reset: aclr pulse with both reqs high → gnt=0, mem_we=0, rvalid=0, p1_wait_max=0. Next cycle after release, p0 is granted.
- Single read: p1 reads addr 0x0010 holding 0x5A → p1_gnt in cycle T, p1_rvalid=1 with rdata=0x5A in T+1 only.
- Contention with default MAX_WAIT=8: both request continuously → p0 granted 8 cycles, p1 granted on the 9th, counter clears, pattern repeats. p1_wait_max=8.
- Exclusive: excl=1, both request for 20 cycles → p1_gnt never asserts. Drop excl with wait_cnt held → p1 granted within 1 cycle if the held count is at MAX_WAIT.
- Write then read: p0 writes 0xA3 to 0x1234, then p1 reads 0x1234 the next cycle → p1_rvalid with 0xA3. Alternating p0/p1 reads → rvalids alternate with no bubble.
- Mid-read reset: p0 read granted, aclr asserted before the next edge → p0_rvalid never asserts. State returns to reset values.
